// File: rtl/reaction_avg_if.sv
// Sample handshake, shared-adder operand bus and result outputs of reaction_avg_sequencer.
// Optional best-time outputs exist only when REACTION_BEST_TIME_EN is defined.
interface reaction_avg_if #(
    parameter int WIDTH     = 13,
    parameter int ACC_WIDTH = 15
);
    logic                 clear;
    logic                 sample_valid;
    logic [WIDTH-1:0]     sample_in;
    logic                 sample_ready;
    logic [2:0]           trial_count;
    logic [ACC_WIDTH-1:0] add_x;
    logic [ACC_WIDTH-1:0] add_y;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 busy;
    logic                 avg_valid;
    logic [WIDTH-1:0]     avg_out;
`ifdef REACTION_BEST_TIME_EN
    logic [WIDTH-1:0]     best_out;
    logic                 best_valid;
`endif

    // Sequencer side
    modport slave (
        input  clear, sample_valid, sample_in, add_sum,
        output sample_ready, trial_count, add_x, add_y, busy, avg_valid, avg_out
`ifdef REACTION_BEST_TIME_EN
        , output best_out, best_valid
`endif
    );

    // Game FSM / external adder side
    modport master (
        output clear, sample_valid, sample_in, add_sum,
        input  sample_ready, trial_count, add_x, add_y, busy, avg_valid, avg_out
`ifdef REACTION_BEST_TIME_EN
        , input best_out, best_valid
`endif
    );
endinterface

// File: rtl/reaction_avg_sequencer.sv
// Buffers four reaction-time samples, sums them through one shared external adder and
// outputs floor(sum/4). Define REACTION_BEST_TIME_EN to add a since-reset best-time tracker.
module reaction_avg_sequencer #(
    parameter int WIDTH       = 13,
    parameter int ACC_WIDTH   = 15,
    parameter int TRIALS_LOG2 = 2
) (
    input  logic           clk,
    input  logic           reset,
    reaction_avg_if.slave  bus
);
    localparam int TRIALS = 1 << TRIALS_LOG2;
    localparam logic [2:0]             LAST_TRIAL = 3'(TRIALS - 1);
    localparam logic [TRIALS_LOG2-1:0] LAST_IDX   = TRIALS_LOG2'(TRIALS - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ACCUM   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             trial_count;
    logic [TRIALS_LOG2-1:0] idx;
    logic [ACC_WIDTH-1:0]   acc;
    logic [WIDTH-1:0]       sbuf [TRIALS];
    logic [WIDTH-1:0]       avg_q;
    logic                   avg_vld_q;
    logic                   accept;
    logic                   abort;
    logic                   sample_ready;
    logic                   busy;
    logic [ACC_WIDTH-1:0]   add_x;
    logic [ACC_WIDTH-1:0]   add_y;

    // Divide by the trial count with truncation: drop the low TRIALS_LOG2 bits.
    function automatic logic [WIDTH-1:0] avg_trunc(input logic [ACC_WIDTH-1:0] sum);
        return sum[WIDTH+TRIALS_LOG2-1:TRIALS_LOG2];
    endfunction

    assign abort  = bus.clear;
    assign accept = bus.sample_valid && (state == COLLECT) && !abort;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && (trial_count == LAST_TRIAL)) state_nxt = ACCUM;
            ACCUM:   if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Adder operands stay at zero outside ACCUM so the shared adder does not toggle.
    always_comb begin
        sample_ready = 1'b0;
        busy         = 1'b0;
        add_x        = '0;
        add_y        = '0;
        case (state)
            COLLECT: sample_ready = 1'b1;
            ACCUM: begin
                busy  = 1'b1;
                add_x = acc;
                add_y = ACC_WIDTH'(sbuf[idx]);
            end
            DONE:    busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            trial_count <= '0;
            idx         <= '0;
            acc         <= '0;
            avg_q       <= '0;
            avg_vld_q   <= 1'b0;
            for (int i = 0; i < TRIALS; i++) sbuf[i] <= '0;
        end else begin
            avg_vld_q <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        sbuf[trial_count[TRIALS_LOG2-1:0]] <= bus.sample_in;
                        trial_count <= trial_count + 3'd1;
                        idx         <= '0;
                        acc         <= '0;
                    end
                end
                ACCUM: begin
                    acc <= bus.add_sum;
                    idx <= idx + TRIALS_LOG2'(1);
                end
                DONE: begin
                    // Result and strobe register together so avg_out is stable while avg_valid is high.
                    avg_q       <= avg_trunc(acc);
                    avg_vld_q   <= 1'b1;
                    trial_count <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.sample_ready = sample_ready;
    assign bus.busy         = busy;
    assign bus.add_x        = add_x;
    assign bus.add_y        = add_y;
    assign bus.trial_count  = trial_count;
    assign bus.avg_out      = avg_q;
    assign bus.avg_valid    = avg_vld_q;

`ifdef REACTION_BEST_TIME_EN
    logic [WIDTH-1:0] best_q;
    logic             best_vld_q;

    // Best time survives a session clear; only reset restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_q     <= '1;
            best_vld_q <= 1'b0;
        end else if (accept) begin
            best_vld_q <= 1'b1;
            if (bus.sample_in < best_q) best_q <= bus.sample_in;
        end
    end

    assign bus.best_out   = best_q;
    assign bus.best_valid = best_vld_q;
`endif
endmodule

// File: doc/reaction_avg_sequencer.md
Name: reaction_avg_sequencer

Overview:
- Collects four 13-bit reaction-time samples (ms) from the game FSM and buffers them.
- Then time-shares one external 15-bit adder to accumulate the four samples, one per cycle.
- Divides the sum by 4 (right shift by 2) and presents the 13-bit average with a one-cycle valid strobe.
- Replaces three parallel adders with one shared adder plus sequencing.

Parameters:
- WIDTH, 13, sample and average width in bits.
- ACC_WIDTH, 15, accumulator and adder width; must be at least WIDTH+2.
- TRIALS_LOG2, 2, log2 of the sample count. Fixed at 2 (4 trials) for this release.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous session abort; same effect as reset on state and buffer.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_in  input  WIDTH  reaction time in ms.
- sample_ready  output  1  high only in COLLECT; a sample is accepted when sample_valid && sample_ready.
- trial_count  output  3  number of samples accepted this session, 0..4.
- add_x  output  ACC_WIDTH  operand X to the shared adder.
- add_y  output  ACC_WIDTH  operand Y to the shared adder, zero-extended buffer entry.
- add_sum  input  ACC_WIDTH  combinational sum from the shared adder (Cin tied 0 externally).
- busy  output  1  high in ACCUM and DONE.
- avg_valid  output  1  one-cycle pulse; avg_out is valid in that cycle.
- avg_out  output  WIDTH  most recent average; held until the next result, reset, or clear.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset and clear values:
  - state = COLLECT, trial_count = 0, accumulator = 0, buffer entries = 0.
  - avg_out = 0, avg_valid = 0, busy = 0, sample_ready = 1 (combinational from state).
  - add_x = 0, add_y = 0.
- Priority: reset > clear > all else. Clear in any state aborts the session; a sample presented in the same cycle as clear is dropped.
- COLLECT:
  - On an accepted sample, write buf[trial_count] <= sample_in and increment trial_count.
  - Accepting the 4th sample moves to ACCUM next cycle, with idx = 0 and acc = 0.
- ACCUM (exactly 4 cycles, idx = 0..3):
  - add_x = acc, add_y = {0, buf[idx]}.
  - On each edge, acc <= add_sum and idx increments.
  - After idx = 3 moves to DONE.
  - sample_ready = 0; sample_valid is ignored (no accept, no error).
- DONE (1 cycle):
  - avg_out <= acc[WIDTH+1:2], i.e. floor(sum/4); avg_valid = 1 this cycle.
  - Next state COLLECT with trial_count <= 0.
- Latency: 4th sample accepted at edge T → avg_valid high in the cycle after edge T+5. Throughput: one average per 4 accepted samples plus 5 cycles.
- Arithmetic:
  - Maximum sum is 4×8191 = 32764, which fits 15 bits; no overflow is possible, and the adder overflow output is left unconnected.
  - Truncating division, no rounding.
- Outside ACCUM, add_x and add_y are held at 0 so the shared adder is quiescent.
- Back-to-back sessions: a sample may be accepted in the first COLLECT cycle after DONE.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- Defined:
  - Adds output best_out [WIDTH-1:0] and output best_valid (1 bit).
  - best_out tracks the minimum accepted sample since reset only; clear does not reset it.
  - best_out resets to all ones (8191) with best_valid = 0.
  - best_valid goes to 1 on the first accepted sample.
  - Compare and update happen on the accept edge; equal values leave best_out unchanged.
- Not defined: neither port exists and there is no comparator logic; all other behaviour is identical.

Test Plan:
- Reset, then samples 100, 200, 300, 400 on consecutive cycles → busy for 5 cycles; avg_valid pulses once with avg_out = 250; trial_count returns to 0.
- Samples 8191 ×4 → avg_out = 8191, with no wrap. Samples 1, 1, 1, 2 → avg_out = 1 (truncation).
- After 4th sample, hold sample_valid = 1 with value 5 through ACCUM/DONE → sample_ready = 0; the value 5 is accepted only in the first COLLECT cycle, where trial_count becomes 1, and it does not affect the current average.
- Accept 2 samples, assert clear together with a 3rd sample → trial_count = 0, no avg_valid. Then 10, 20, 30, 40 → avg_out = 25.
- Assert reset mid-ACCUM (idx = 2) → next cycle state COLLECT, avg_out = 0, busy = 0, add_x = add_y = 0, no avg_valid.
- With REACTION_BEST_TIME_EN: samples 300, 150, 150, 900 → best_out = 150, best_valid = 1. After clear, best_out is still 150. Then sample 120 → best_out = 120.
